// File: rtl/pool_column_feeder.sv
// pool_column_feeder
//   Upstream feeder for the max-pool stage. Takes a raster pixel stream, one
//   pixel per handshake, and buffers the first two rows of every 3-row band.
//   During the third row it emits vertical 3-pixel columns (top, middle,
//   current). It drives the pool stage's en/init so that the stage computes
//   non-overlapping 3x3 maxima, and it flags the cycle in which a finished
//   window maximum is on the pool stage's output.
//
// Ports
//   clk_i        clock
//   reset_i      synchronous, active-high reset
//   valid_i      data_i carries a valid pixel
//   data_i       raster pixel, row-major, top-left first
//   ready_o      feeder can accept a pixel (low for one cycle after reset)
//   col_o        [0]=row r-2, [1]=row r-1, [2]=row r, same column
//   en_o         col_o valid; drives max-pool en
//   init_o       first column of a 3x3 window; drives max-pool init
//   pool_done_o  max-pool output now holds a finished window max
//   pool_col_o   output-column index of the finished window
//   frame_last_o with pool_done_o: last window of the frame
module pool_column_feeder #(
  parameter int width_p      = 8,
  parameter int img_width_p  = 24,
  parameter int img_height_p = 24
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic [2:0][width_p-1:0]  col_o,
  output logic                     en_o,
  output logic                     init_o,
  output logic                     pool_done_o,
  output logic [((img_width_p/3 > 1) ? $clog2(img_width_p/3) : 1)-1:0] pool_col_o,
  output logic                     frame_last_o
);

  localparam int pools_lp  = img_width_p / 3;
  localparam int bands_lp  = img_height_p / 3;
  localparam int col_w_lp  = $clog2(img_width_p);
  localparam int pc_w_lp   = (pools_lp > 1) ? $clog2(pools_lp) : 1;
  localparam int band_w_lp = (bands_lp > 1) ? $clog2(bands_lp) : 1;

  typedef enum logic [1:0] {ROW0, ROW1, ROW2} row_state_e;

  row_state_e state_q, state_n;

  logic [col_w_lp-1:0]  col_cnt_q;
  logic [1:0]           win_cnt_q;
  logic [pc_w_lp-1:0]   pool_col_q;
  logic [band_w_lp-1:0] band_cnt_q;

  logic [width_p-1:0] lb0 [img_width_p];
  logic [width_p-1:0] lb1 [img_width_p];

  logic               last_win_q;
  logic               last_frame_q;
  logic [pc_w_lp-1:0] win_pc_q;

  logic accept, emit, row_end, win_end, pool_end, band_end;

  assign accept   = valid_i & ready_o;
  assign emit     = accept && (state_q == ROW2);
  assign row_end  = (col_cnt_q == col_w_lp'(img_width_p - 1));
  assign win_end  = (win_cnt_q == 2'd2);
  assign pool_end = (pool_col_q == pc_w_lp'(pools_lp - 1));
  assign band_end = (band_cnt_q == band_w_lp'(bands_lp - 1));

  // Row-phase state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ROW0;
    else         state_q <= state_n;
  end

  // The row phase moves on only with the last pixel of a row.
  always_comb begin
    state_n = state_q;
    if (accept && row_end) begin
      unique case (state_q)
        ROW0:    state_n = ROW1;
        ROW1:    state_n = ROW2;
        ROW2:    state_n = ROW0;
        default: state_n = ROW0;
      endcase
    end
  end

  // No backpressure: the only time the feeder refuses a pixel is the cycle
  // right after reset.
  always_ff @(posedge clk_i) begin
    ready_o <= ~reset_i;
  end

  // Raster position counters. The row width is a multiple of 3, so the
  // window and pool-column counters return to zero together with col_cnt.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_cnt_q  <= '0;
      win_cnt_q  <= '0;
      pool_col_q <= '0;
      band_cnt_q <= '0;
    end else if (accept) begin
      col_cnt_q <= row_end ? '0 : col_cnt_q + 1'b1;
      win_cnt_q <= win_end ? 2'd0 : win_cnt_q + 2'd1;
      if (win_end)
        pool_col_q <= pool_end ? '0 : pool_col_q + 1'b1;
      if ((state_q == ROW2) && row_end)
        band_cnt_q <= band_end ? '0 : band_cnt_q + 1'b1;
    end
  end

  // Line buffers hold the top two rows of the band. They are written only in
  // ROW0/ROW1 and read only in ROW2, so a read never sees a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (accept && (state_q == ROW0)) lb0[col_cnt_q] <= data_i;
    if (accept && (state_q == ROW1)) lb1[col_cnt_q] <= data_i;
  end

  // First output stage: present the column to the pool stage. col_o holds
  // its value between columns; the window tags ride along for stage two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_o        <= '0;
      en_o         <= 1'b0;
      init_o       <= 1'b0;
      last_win_q   <= 1'b0;
      last_frame_q <= 1'b0;
      win_pc_q     <= '0;
    end else begin
      en_o       <= emit;
      init_o     <= emit && (win_cnt_q == 2'd0);
      last_win_q <= emit && win_end;
      if (emit) begin
        col_o        <= {data_i, lb1[col_cnt_q], lb0[col_cnt_q]};
        win_pc_q     <= pool_col_q;
        last_frame_q <= row_end && band_end;
      end
    end
  end

  // Second output stage: the pool stage registers the closing column on the
  // edge after en, so the finished flag lags the column by one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pool_done_o  <= 1'b0;
      frame_last_o <= 1'b0;
      pool_col_o   <= '0;
    end else begin
      pool_done_o  <= last_win_q;
      frame_last_o <= last_win_q && last_frame_q;
      if (last_win_q)
        pool_col_o <= win_pc_q;
    end
  end

endmodule

// File: tb/tb_pool_column_feeder.sv
module tb_pool_column_feeder;

  localparam int W  = 8;
  localparam int IW = 6;
  localparam int IH = 6;
  localparam int NPIX = IW * IH;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            valid = 1'b0;
  logic [W-1:0]    data = '0;
  logic            ready_o;
  logic [2:0][W-1:0] col_o;
  logic            en_o, init_o, pool_done_o, frame_last_o;
  logic [0:0]      pool_col_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_column_feeder #(.width_p(W), .img_width_p(IW), .img_height_p(IH)) dut (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .data_i(data),
    .ready_o(ready_o), .col_o(col_o), .en_o(en_o), .init_o(init_o),
    .pool_done_o(pool_done_o), .pool_col_o(pool_col_o), .frame_last_o(frame_last_o)
  );

  // Downstream max-pool stage: registers on en, output is the accumulator.
  logic [W-1:0] pool_acc = '0;

  function automatic logic [W-1:0] max2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    if (reset) pool_acc <= '0;
    else if (en_o)
      pool_acc <= init_o ? max2(max2(col_o[0], col_o[1]), col_o[2])
                         : max2(pool_acc, max2(max2(col_o[0], col_o[1]), col_o[2]));
  end

  // Scoreboard
  typedef struct { logic [2:0][W-1:0] col; logic init; int cyc; } col_exp_t;
  typedef struct { logic [W-1:0] mx; int pc; logic last; int cyc; } pool_exp_t;
  col_exp_t  col_q[$];
  pool_exp_t pool_q[$];

  // Reference model: the frame image as a 2-D array filled in raster order.
  logic [W-1:0] img [IH][IW];
  int pix_idx = 0;
  int accepted = 0;
  int pool_seen = 0;
  int fl_seen = 0;
  logic [2:0][W-1:0] last_col = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic modelAccept(input logic [W-1:0] d);
    int r, c;
    col_exp_t ce;
    pool_exp_t pe;
    r = pix_idx / IW;
    c = pix_idx % IW;
    img[r][c] = d;
    if (r % 3 == 2) begin
      ce.col[2] = d;
      ce.col[1] = img[r-1][c];
      ce.col[0] = img[r-2][c];
      ce.init = (c % 3 == 0);
      ce.cyc = cyc + 1;
      col_q.push_back(ce);
      if (c % 3 == 2) begin
        pe.mx = '0;
        for (int rr = r - 2; rr <= r; rr++)
          for (int cc = c - 2; cc <= c; cc++)
            if (img[rr][cc] > pe.mx) pe.mx = img[rr][cc];
        pe.pc = c / 3;
        pe.last = (pix_idx == NPIX - 1);
        pe.cyc = cyc + 2;
        pool_q.push_back(pe);
      end
    end
    pix_idx = (pix_idx + 1) % NPIX;
    accepted++;
  endtask

  // Drive one cycle; the model learns of the accept before the edge happens.
  task automatic applyStimulus(input bit v, input logic [W-1:0] d);
    @(negedge clk);
    #1;
    valid = v;
    data = d;
    if (v && ready_o) modelAccept(d);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    valid = 1'b0;
    col_q.delete();
    pool_q.delete();
    pix_idx = 0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) applyStimulus(1'b0, '0);
    checkOutput({name, "_col_sb_empty"}, col_q.size(), 0);
    checkOutput({name, "_pool_sb_empty"}, pool_q.size(), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a column or result.
  always @(negedge clk) begin
    col_exp_t ce;
    pool_exp_t pe;
    if (reset) begin
      checkOutput("reset_outputs",
                  {7'd0, ready_o, en_o, init_o, pool_done_o, frame_last_o, pool_col_o, col_o},
                  32'd0);
      last_col = '0;
    end else begin
      if (en_o) begin
        if (col_q.size() == 0) begin
          checkOutput("unexpected_en", 32'd1, 32'd0);
        end else begin
          ce = col_q.pop_front();
          checkOutput("col_o", col_o, ce.col);
          checkOutput("init_o", init_o, ce.init);
          checkOutput("en_latency", cyc, ce.cyc);
        end
        last_col = col_o;
      end else begin
        checkOutput("init_without_en", init_o, 1'b0);
        checkOutput("col_hold", col_o, last_col);
      end
      if (pool_done_o) begin
        pool_seen++;
        if (frame_last_o) fl_seen++;
        if (pool_q.size() == 0) begin
          checkOutput("unexpected_pool_done", 32'd1, 32'd0);
        end else begin
          pe = pool_q.pop_front();
          checkOutput("pool_max", pool_acc, pe.mx);
          checkOutput("pool_col_o", pool_col_o, pe.pc);
          checkOutput("frame_last_o", frame_last_o, pe.last);
          checkOutput("done_latency", cyc, pe.cyc);
        end
      end else begin
        checkOutput("frame_last_without_done", frame_last_o, 1'b0);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int p0, f0, target, guard;

    // Reset, then idle.
    doReset();
    checkOutput("ready_first_cycle", ready_o, 1'b0);
    repeat (3) applyStimulus(1'b0, '0);
    checkOutput("ready_idle", ready_o, 1'b1);
    checkOutput("idle_en", en_o, 1'b0);
    checkOutput("idle_done", pool_done_o, 1'b0);

    // Ramp frame, continuous valid.
    p0 = pool_seen; f0 = fl_seen;
    for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, W'(i));
    drain("ramp");
    checkOutput("ramp_done_count", pool_seen - p0, 4);
    checkOutput("ramp_last_count", fl_seen - f0, 1);

    // Ramp frame, valid toggling.
    p0 = pool_seen;
    for (int i = 0; i < NPIX; i++) begin
      applyStimulus(1'b1, W'(i));
      applyStimulus(1'b0, W'($urandom));
    end
    drain("toggle");
    checkOutput("toggle_done_count", pool_seen - p0, 4);

    // Single bright pixel at row 2, column 4.
    for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, (i == 2 * IW + 4) ? 8'd255 : 8'd0);
    drain("spot");

    // Reset in ROW2 of band 0 with a window close in flight.
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, W'($urandom));
    doReset();
    repeat (6) applyStimulus(1'b0, '0);
    p0 = pool_seen; f0 = fl_seen;
    for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, W'(i));
    drain("post_reset");
    checkOutput("post_reset_done_count", pool_seen - p0, 4);
    checkOutput("post_reset_last_count", fl_seen - f0, 1);

    // Two back-to-back random frames with random valid gaps.
    p0 = pool_seen; f0 = fl_seen;
    target = accepted + 2 * NPIX;
    guard = 0;
    while (accepted < target && guard < 2000) begin
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom));
      guard++;
    end
    checkOutput("random_accepts", accepted, target);
    drain("random");
    checkOutput("random_done_count", pool_seen - p0, 8);
    checkOutput("random_last_count", fl_seen - f0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
